// File: rtl/lock_game_pkg.sv
// Shared definitions for the lock game controller: state encoding,
// power codes and small helpers used by the controller.
package lock_game_pkg;

  // State encoding is visible on the state port and is decoded by the display logic.
  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_ROLE        = 4'd1,
    S_PICK_C      = 4'd2,
    S_PICK_B      = 4'd3,
    S_SHOW_C      = 4'd4,
    S_SHOW_B      = 4'd5,
    S_SET_CODE    = 4'd10,
    S_GUESS       = 4'd11,
    S_CODER_WIN   = 4'd13,
    S_BREAKER_WIN = 4'd14,
    S_GAME_OVER   = 4'd15
  } state_t;

  typedef enum logic [1:0] {
    PWR_NONE  = 2'b00,
    PWR_INVIS = 2'b01,
    PWR_FLEX  = 2'b10,
    PWR_CAMO  = 2'b11
  } power_t;

  // Power given to a player who leaves the selector at NONE when the pick window closes.
  localparam power_t DEFAULT_POWER = PWR_INVIS;

  // States that run the shared cycle timer.
  function automatic logic is_timed(input state_t s);
    return (s == S_PICK_C) || (s == S_PICK_B) ||
           (s == S_SHOW_C) || (s == S_SHOW_B) ||
           (s == S_GUESS)  ||
           (s == S_CODER_WIN) || (s == S_BREAKER_WIN);
  endfunction

  // Resolve the selector value latched at the end of a pick window.
  function automatic logic [1:0] pick_power(input logic [1:0] sel);
    return (sel == PWR_NONE) ? DEFAULT_POWER : sel;
  endfunction

endpackage

// File: rtl/game_timer.sv
// Load/decrement cycle counter shared by all timed states.
// value holds the clocks remaining; expired flags the last cycle (value==1).
module game_timer #(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         expired
);

  // Load on request, otherwise count down and rest at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - W'(1);
    end
  end

  assign expired = (value == W'(1));

endmodule

// File: rtl/lock_game_controller.sv
// Lock game controller: role selection, power picks, secret-code entry,
// multi-try timed guessing, best-of-N scoring and replay.
//
// code_valid/code_data: single-cycle strobe from the IR decoder with no
// back-pressure. code_data is meaningful only in the cycle code_valid is high;
// each high cycle is one event (back-to-back strobes are separate events).
// Strobes are consumed only in SET_CODE (with confirm high) and GUESS.
module lock_game_controller
  import lock_game_pkg::*;
#(
  parameter int CODE_W        = 8,
  parameter int TIMER_W       = 28,
  parameter int PICK_CYCLES   = 250_000_000,
  parameter int SHOW_CYCLES   = 250_000_000,
  parameter int GUESS_CYCLES  = 250_000_000,
  parameter int RESULT_CYCLES = 100_000_000,
  parameter int MAX_TRIES     = 3,
  parameter int ROUNDS        = 3,
  parameter int SCORE_W       = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            role_coder,
  input  logic                            role_breaker,
  input  logic [1:0]                      power_sel,
  input  logic                            confirm,
  input  logic                            code_valid,
  input  logic [CODE_W-1:0]               code_data,
  input  logic                            replay,
  output logic [3:0]                      state,
  output logic [1:0]                      coder_power,
  output logic [1:0]                      breaker_power,
  output logic [TIMER_W-1:0]              timer_value,
  output logic [$clog2(MAX_TRIES+1)-1:0]  tries_left,
  output logic [$clog2(ROUNDS+1)-1:0]     round_num,
  output logic [SCORE_W-1:0]              coder_score,
  output logic [SCORE_W-1:0]              breaker_score,
  output logic                            coder_win_led,
  output logic                            breaker_win_led,
  output logic                            game_over
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int RND_W = $clog2(ROUNDS + 1);

  // A zero-length window still lasts one clock so the FSM cannot stall.
  localparam logic [TIMER_W-1:0] PICK_LOAD   = (PICK_CYCLES   == 0) ? TIMER_W'(1) : TIMER_W'(PICK_CYCLES);
  localparam logic [TIMER_W-1:0] SHOW_LOAD   = (SHOW_CYCLES   == 0) ? TIMER_W'(1) : TIMER_W'(SHOW_CYCLES);
  localparam logic [TIMER_W-1:0] GUESS_LOAD  = (GUESS_CYCLES  == 0) ? TIMER_W'(1) : TIMER_W'(GUESS_CYCLES);
  localparam logic [TIMER_W-1:0] RESULT_LOAD = (RESULT_CYCLES == 0) ? TIMER_W'(1) : TIMER_W'(RESULT_CYCLES);

  localparam logic [TRY_W-1:0] TRIES_FULL = TRY_W'(MAX_TRIES);
  localparam logic [RND_W-1:0] ROUNDS_MAX = RND_W'(ROUNDS);

  state_t              state_q;
  state_t              next_state;
  logic                timer_load;
  logic [TIMER_W-1:0]  timer_load_val;
  logic                timer_expired;
  logic [CODE_W-1:0]   code_q;

  logic                code_accept;
  logic                code_zero;
  logic                guess_hit;
  logic                last_try;
  logic                round_last;
  logic                powers_set;
  logic                enter_cwin;
  logic                enter_bwin;
  logic                result_done;

  game_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_load_val),
    .value    (timer_value),
    .expired  (timer_expired)
  );

  assign code_accept = confirm && code_valid;
  assign code_zero   = (code_data == '0);
  assign guess_hit   = (code_data == code_q);
  assign last_try    = (tries_left == TRY_W'(1));
  assign round_last  = (round_num == ROUNDS_MAX);
  assign powers_set  = (coder_power != PWR_NONE) && (breaker_power != PWR_NONE);
  assign enter_cwin  = (next_state == S_CODER_WIN)   && (state_q != S_CODER_WIN);
  assign enter_bwin  = (next_state == S_BREAKER_WIN) && (state_q != S_BREAKER_WIN);
  assign result_done = ((state_q == S_CODER_WIN) || (state_q == S_BREAKER_WIN)) && timer_expired;

  assign state = state_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // Next-state decode; in GUESS a strobe is judged before timer expiry.
  always_comb begin
    next_state = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) next_state = S_ROLE;
      end
      S_ROLE: begin
        if (role_coder)        next_state = S_PICK_C;
        else if (role_breaker) next_state = S_PICK_B;
      end
      S_PICK_C: begin
        if (timer_expired) next_state = S_SHOW_C;
      end
      S_PICK_B: begin
        if (timer_expired) next_state = S_SHOW_B;
      end
      S_SHOW_C: begin
        if (timer_expired) next_state = powers_set ? S_SET_CODE : S_PICK_B;
      end
      S_SHOW_B: begin
        if (timer_expired) next_state = powers_set ? S_SET_CODE : S_PICK_C;
      end
      S_SET_CODE: begin
        if (code_accept) next_state = code_zero ? S_BREAKER_WIN : S_GUESS;
      end
      S_GUESS: begin
        if (code_valid && guess_hit)     next_state = S_BREAKER_WIN;
        else if (code_valid && last_try) next_state = S_CODER_WIN;
        else if (timer_expired)          next_state = S_CODER_WIN;
      end
      S_CODER_WIN, S_BREAKER_WIN: begin
        if (timer_expired) next_state = round_last ? S_GAME_OVER : S_ROLE;
      end
      S_GAME_OVER: begin
        if (replay) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Moore outputs plus the timer load issued on the edge that enters a timed state.
  always_comb begin
    coder_win_led   = (state_q == S_CODER_WIN);
    breaker_win_led = (state_q == S_BREAKER_WIN);
    game_over       = (state_q == S_GAME_OVER);
    timer_load      = (next_state != state_q) && is_timed(next_state);
    timer_load_val  = '0;
    case (next_state)
      S_PICK_C, S_PICK_B:         timer_load_val = PICK_LOAD;
      S_SHOW_C, S_SHOW_B:         timer_load_val = SHOW_LOAD;
      S_GUESS:                    timer_load_val = GUESS_LOAD;
      S_CODER_WIN, S_BREAKER_WIN: timer_load_val = RESULT_LOAD;
      default:                    timer_load_val = '0;
    endcase
  end

  // Game data: powers, secret code, tries, round count and scores.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coder_power   <= PWR_NONE;
      breaker_power <= PWR_NONE;
      code_q        <= '0;
      tries_left    <= '0;
      round_num     <= '0;
      coder_score   <= '0;
      breaker_score <= '0;
    end else begin
      if ((state_q == S_PICK_C) && timer_expired) begin
        coder_power <= pick_power(power_sel);
      end
      if ((state_q == S_PICK_B) && timer_expired) begin
        breaker_power <= pick_power(power_sel);
      end
      if ((state_q == S_SET_CODE) && code_accept && !code_zero) begin
        code_q     <= code_data;
        tries_left <= TRIES_FULL;
      end
      if ((state_q == S_GUESS) && code_valid && !guess_hit && (tries_left != '0)) begin
        tries_left <= tries_left - TRY_W'(1);
      end
      if (enter_cwin) begin
        if (coder_score != '1) coder_score <= coder_score + SCORE_W'(1);
        if (!round_last)       round_num   <= round_num + RND_W'(1);
      end
      if (enter_bwin) begin
        if (breaker_score != '1) breaker_score <= breaker_score + SCORE_W'(1);
        if (!round_last)         round_num     <= round_num + RND_W'(1);
      end
      if (result_done && !round_last) begin
        coder_power   <= PWR_NONE;
        breaker_power <= PWR_NONE;
        code_q        <= '0;
      end
      if ((state_q == S_GAME_OVER) && replay) begin
        coder_power   <= PWR_NONE;
        breaker_power <= PWR_NONE;
        code_q        <= '0;
        tries_left    <= '0;
        round_num     <= '0;
        coder_score   <= '0;
        breaker_score <= '0;
      end
    end
  end

endmodule
